fpu_stream_ctrl: RTL and testbench

FPU_STREAM_CTRL -- requirements
Module: fpu_stream_ctrl

---
 rtl/fpu_stream_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_fpu_stream_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_stream_ctrl.sv
// Operand FIFO + result register feeding a combinational bfloat16 FPU; optional overflow counter via FPU_STREAM_OVF_CNT_EN.
// Latency: 2 edges push-to-result, one result per cycle when res_ready_i is held high.
// Backpressure: in_ready_o depends only on FIFO occupancy; a stalled result register holds its data and stalls the FIFO head.

module fpu_stream_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

module fpu_stream_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MODE_WIDTH = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [MODE_WIDTH-1:0] in_op_i,
  input  logic [DATA_WIDTH-1:0] in_a_i,
  input  logic [DATA_WIDTH-1:0] in_b_i,
  output logic [MODE_WIDTH-1:0] fpu_op_o,
  output logic [DATA_WIDTH-1:0] fpu_in1_o,
  output logic [DATA_WIDTH-1:0] fpu_in2_o,
  input  logic [DATA_WIDTH-1:0] fpu_out_i,
  input  logic                  fpu_overflow_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  res_ovf_o,
`ifdef FPU_STREAM_OVF_CNT_EN
  output logic                  ovf_sticky_o,
  output logic [15:0]           ovf_count_o
`else
  output logic                  ovf_sticky_o
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [MODE_WIDTH-1:0] op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } req_t;

  req_t             in_req, head_req;
  logic [CNT_W-1:0] count;
  logic             fifo_nempty, push, pop;

  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q,  res_data_d;
  logic                  res_ovf_q,   res_ovf_d;
  logic                  ovf_sticky_q, ovf_sticky_d;

  assign in_req      = '{op: in_op_i, a: in_a_i, b: in_b_i};
  assign fifo_nempty = (count != '0);
  assign in_ready_o  = (count < CNT_W'(FIFO_DEPTH));
  assign push        = in_valid_i && in_ready_o;
  // The head moves into the result register whenever that register is free or being drained.
  assign pop         = fifo_nempty && (!res_valid_q || res_ready_i);

  fpu_stream_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_req),
    .rdata_o (head_req),
    .count_o (count)
  );

  assign fpu_op_o  = fifo_nempty ? head_req.op : '0;
  assign fpu_in1_o = fifo_nempty ? head_req.a  : '0;
  assign fpu_in2_o = fifo_nempty ? head_req.b  : '0;

  always_comb begin
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_ovf_d    = res_ovf_q;
    ovf_sticky_d = ovf_sticky_q;
    if (flush_i) begin
      res_valid_d  = 1'b0;
      res_data_d   = '0;
      res_ovf_d    = 1'b0;
      ovf_sticky_d = 1'b0;
    end else if (pop) begin
      res_valid_d  = 1'b1;
      res_data_d   = fpu_out_i;
      res_ovf_d    = fpu_overflow_i;
      ovf_sticky_d = ovf_sticky_q | fpu_overflow_i;
    end else if (res_valid_q && res_ready_i) begin
      res_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_ovf_q    <= res_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_ovf_o    = res_ovf_q;
  assign ovf_sticky_o = ovf_sticky_q;

`ifdef FPU_STREAM_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (flush_i) begin
      ovf_cnt_d = '0;
    end else if (pop && fpu_overflow_i && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_cnt_q <= '0;
    else         ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count_o = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_fpu_stream_ctrl.sv
// Randomized and directed bench for fpu_stream_ctrl with a transaction-level queue model and a stand-in FPU.
module tb_fpu_stream_ctrl;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [1:0]  in_op = '0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_ready, res_valid, res_ovf, ovf_sticky, fpu_ovf;
  logic [1:0]  fpu_op;
  logic [15:0] fpu_in1, fpu_in2, fpu_out, res_data;
`ifdef FPU_STREAM_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] fpu_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 2'd0 && a == 16'h3F80 && b == 16'h4000) return 16'h4040;
    return (a ^ {b[7:0], b[15:8]}) + {14'd0, op};
  endfunction

  function automatic logic ovf_fn(input logic [15:0] a);
    return a[14:7] == 8'hFF;
  endfunction

  function automatic item_t mk(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    item_t it;
    it.op = op; it.a = a; it.b = b;
    return it;
  endfunction

  assign fpu_out = fpu_fn(fpu_op, fpu_in1, fpu_in2);
  assign fpu_ovf = ovf_fn(fpu_in1);

  fpu_stream_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_op_i        (in_op),
    .in_a_i         (in_a),
    .in_b_i         (in_b),
    .fpu_op_o       (fpu_op),
    .fpu_in1_o      (fpu_in1),
    .fpu_in2_o      (fpu_in2),
    .fpu_out_i      (fpu_out),
    .fpu_overflow_i (fpu_ovf),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
    .res_ovf_o      (res_ovf),
`ifdef FPU_STREAM_OVF_CNT_EN
    .ovf_sticky_o   (ovf_sticky),
    .ovf_count_o    (ovf_count)
`else
    .ovf_sticky_o   (ovf_sticky)
`endif
  );

  // Reference model: pending operand queue plus one result slot.
  item_t       m_fq[$];
  bit          m_rv;
  logic [15:0] m_rd;
  bit          m_ro, m_sticky;
  int          m_ocnt;

  task automatic model_reset();
    m_fq.delete();
    m_rv = 0; m_rd = '0; m_ro = 0; m_sticky = 0; m_ocnt = 0;
  endtask

  task automatic tick(input bit vld, input item_t it, input bit rdy, input bit fl);
    bit do_push, do_pop;
    item_t h;
    in_valid = vld; in_op = it.op; in_a = it.a; in_b = it.b;
    res_ready = rdy; flush = fl;
    if (fl) begin
      model_reset();
    end else begin
      do_push = vld && (m_fq.size() < DEPTH);
      do_pop  = (m_fq.size() > 0) && (!m_rv || rdy);
      if (do_pop) begin
        h = m_fq.pop_front();
        m_rv = 1; m_rd = fpu_fn(h.op, h.a, h.b); m_ro = ovf_fn(h.a);
        if (m_ro) begin
          m_sticky = 1;
          if (m_ocnt < 65535) m_ocnt++;
        end
      end else if (m_rv && rdy) begin
        m_rv = 0;
      end
      if (do_push) m_fq.push_back(it);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
    checks++; if (res_data !== 16'h0) begin errors++; $display("FAIL rst_res_data got %h exp 0000", res_data); end
    checks++; if (ovf_sticky !== 1'b0 || res_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b%b exp 00", ovf_sticky, res_ovf); end
    checks++; if ({fpu_op, fpu_in1, fpu_in2} !== 34'h0) begin errors++; $display("FAIL rst_fpu_out got %h exp 0", {fpu_op, fpu_in1, fpu_in2}); end
    rst_n = 1'b1;
    tick(0, mk(0, 0, 0), 0, 0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single_op();
    tick(1, mk(2'd0, 16'h3F80, 16'h4000), 0, 0);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_k_valid got %b exp 0", res_valid); end
    checks++; if (fpu_in1 !== 16'h3F80 || fpu_in2 !== 16'h4000) begin errors++; $display("FAIL single_head got %h/%h exp 3f80/4000", fpu_in1, fpu_in2); end
    tick(0, mk(0, 0, 0), 0, 0);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_k1_valid got %b exp 1", res_valid); end
    checks++; if (res_data !== 16'h4040 || res_ovf !== 1'b0) begin errors++; $display("FAIL single_data got %h ovf %b exp 4040 ovf 0", res_data, res_ovf); end
    checks++; if (fpu_in1 !== 16'h0) begin errors++; $display("FAIL single_empty_fpu got %h exp 0000", fpu_in1); end
    tick(0, mk(0, 0, 0), 1, 0);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", res_valid); end
  endtask

  function automatic item_t bp_item(input int i);
    return mk(2'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i * 3));
  endfunction

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      tick(1, bp_item(i), 0, 0);
      if (i == 3) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_before_full got %b exp 1", in_ready); end
      end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", in_ready); end
    checks++; if (res_valid !== 1'b1 || res_data !== fpu_fn(2'd0, 16'h1000, 16'h2000)) begin errors++; $display("FAIL bp_held got v%b %h exp v1 %h", res_valid, res_data, fpu_fn(2'd0, 16'h1000, 16'h2000)); end
    tick(1, mk(2'd1, 16'h5555, 16'h6666), 0, 0);
    checks++; if (res_data !== fpu_fn(2'd0, 16'h1000, 16'h2000) || in_ready !== 1'b0) begin errors++; $display("FAIL bp_stable got %h rdy %b exp %h rdy 0", res_data, in_ready, fpu_fn(2'd0, 16'h1000, 16'h2000)); end
  endtask

  task automatic test_full_simul();
    logic [15:0] got[$];
    item_t x = mk(2'd3, 16'h0ABC, 16'h0DEF);
    if (res_valid) got.push_back(res_data);
    tick(1, x, 1, 0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_frees got %b exp 1", in_ready); end
    if (res_valid) got.push_back(res_data);
    tick(1, x, 1, 0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_simul_count got %b exp 1", in_ready); end
    for (int n = 0; n < 20 && (res_valid || fpu_in1 != 16'h0); n++) begin
      if (res_valid) got.push_back(res_data);
      tick(0, x, 1, 0);
    end
    checks++; if (got.size() != 6) begin errors++; $display("FAIL full_result_count got %0d exp 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      item_t e = (i < 5) ? bp_item(i) : x;
      checks++; if (got[i] !== fpu_fn(e.op, e.a, e.b)) begin errors++; $display("FAIL full_order[%0d] got %h exp %h", i, got[i], fpu_fn(e.op, e.a, e.b)); end
    end
  endtask

  task automatic test_overflow();
    item_t ops[5];
    int    nd = 0;
    ops[0] = mk(2'd1, 16'h7F80, 16'h0001); ops[1] = mk(2'd2, 16'h1234, 16'h0002);
    ops[2] = mk(2'd1, 16'hFF81, 16'h0003); ops[3] = mk(2'd0, 16'h4321, 16'h0004);
    ops[4] = mk(2'd3, 16'h7FC0, 16'h0005);
    tick(0, ops[0], 0, 1);
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b exp 0", ovf_sticky); end
    for (int i = 0; i < 12; i++) begin
      if (res_valid && nd < 5) begin
        checks++; if (res_ovf !== ovf_fn(ops[nd].a) || res_data !== fpu_fn(ops[nd].op, ops[nd].a, ops[nd].b)) begin errors++; $display("FAIL ovf_res[%0d] got %h/%b exp %h/%b", nd, res_data, res_ovf, fpu_fn(ops[nd].op, ops[nd].a, ops[nd].b), ovf_fn(ops[nd].a)); end
        nd++;
      end
      tick(i < 5, ops[i % 5], 1, 0);
    end
    checks++; if (nd != 5) begin errors++; $display("FAIL ovf_delivered got %0d exp 5", nd); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf_sticky); end
`ifdef FPU_STREAM_OVF_CNT_EN
    checks++; if (ovf_count !== 16'd3) begin errors++; $display("FAIL ovf_count got %0d exp 3", ovf_count); end
`endif
  endtask

  task automatic test_flush();
    tick(1, mk(2'd0, 16'h7F80, 16'h1111), 0, 0);
    tick(1, mk(2'd1, 16'h2222, 16'h3333), 0, 0);
    tick(1, mk(2'd2, 16'h4444, 16'h5555), 0, 0);
    checks++; if (ovf_sticky !== 1'b1 || res_valid !== 1'b1) begin errors++; $display("FAIL flush_pre got sticky %b v %b exp 1 1", ovf_sticky, res_valid); end
    tick(1, mk(2'd3, 16'h6666, 16'h7777), 0, 1);
    checks++; if (res_valid !== 1'b0 || ovf_sticky !== 1'b0) begin errors++; $display("FAIL flush_state got v %b sticky %b exp 0 0", res_valid, ovf_sticky); end
    checks++; if (in_ready !== 1'b1 || fpu_in1 !== 16'h0) begin errors++; $display("FAIL flush_empty got rdy %b head %h exp 1 0000", in_ready, fpu_in1); end
`ifdef FPU_STREAM_OVF_CNT_EN
    checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", ovf_count); end
`endif
    tick(0, mk(0, 0, 0), 1, 0);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %b exp 0", res_valid); end
  endtask

  task automatic test_async_reset();
    tick(1, mk(2'd0, 16'h7F80, 16'h0001), 0, 0);
    tick(1, mk(2'd1, 16'h0102, 16'h0304), 0, 0);
    tick(1, mk(2'd2, 16'h0506, 16'h0708), 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0 || res_data !== 16'h0 || res_ovf !== 1'b0) begin errors++; $display("FAIL arst_res got v%b %h %b exp 0 0000 0", res_valid, res_data, res_ovf); end
    checks++; if (ovf_sticky !== 1'b0 || in_ready !== 1'b1 || fpu_in1 !== 16'h0) begin errors++; $display("FAIL arst_ctrl got sticky %b rdy %b head %h exp 0 1 0000", ovf_sticky, in_ready, fpu_in1); end
    in_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    tick(1, mk(2'd0, 16'h3F80, 16'h4000), 1, 0);
    tick(0, mk(0, 0, 0), 1, 0);
    checks++; if (res_valid !== 1'b1 || res_data !== 16'h4040) begin errors++; $display("FAIL arst_restart got v%b %h exp v1 4040", res_valid, res_data); end
    tick(0, mk(0, 0, 0), 1, 0);
  endtask

  task automatic test_random();
    item_t it;
    item_t hd;
    for (int c = 0; c < 400; c++) begin
      it = mk(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 7) == 0) it.a = {it.a[15], 8'hFF, it.a[6:0]};
      tick($urandom_range(0, 3) != 0, it, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
      hd = (m_fq.size() > 0) ? m_fq[0] : mk(0, 0, 0);
      checks++; if (in_ready !== (m_fq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, in_ready, m_fq.size() < DEPTH); end
      checks++; if (res_valid !== m_rv) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, res_valid, m_rv); end
      if (m_rv) begin
        checks++; if (res_data !== m_rd || res_ovf !== m_ro) begin errors++; $display("FAIL rnd_data c%0d got %h/%b exp %h/%b", c, res_data, res_ovf, m_rd, m_ro); end
      end
      checks++; if (ovf_sticky !== m_sticky) begin errors++; $display("FAIL rnd_sticky c%0d got %b exp %b", c, ovf_sticky, m_sticky); end
      checks++; if ({fpu_op, fpu_in1, fpu_in2} !== {hd.op, hd.a, hd.b}) begin errors++; $display("FAIL rnd_head c%0d got %h exp %h", c, {fpu_op, fpu_in1, fpu_in2}, {hd.op, hd.a, hd.b}); end
`ifdef FPU_STREAM_OVF_CNT_EN
      checks++; if (ovf_count !== 16'(m_ocnt)) begin errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, ovf_count, m_ocnt); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_backpressure();
    test_full_simul();
    test_overflow();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
